// File: rtl/mmio_router_if.sv
// Bus bundle between the memory stage (upstream) and the MMIO targets
// (downstream). The router connects through the slave modport; the
// requester/target environment uses the master modport.
interface mmio_router_if #(
  parameter int XLEN  = 32,
  parameter int NPORT = 4
);
  // upstream request
  logic                  up_req_valid;
  logic                  up_req_ready;
  logic [XLEN-1:0]       up_req_addr;
  logic                  up_req_wen;
  logic [XLEN-1:0]       up_req_wdata;
  logic [XLEN/8-1:0]     up_req_wmask;
  // upstream response
  logic                  up_resp_valid;
  logic [XLEN-1:0]       up_resp_rdata;
  logic                  up_resp_error;
  logic [1:0]            up_resp_errty;
  // downstream requests (payload broadcast to all ports)
  logic [NPORT-1:0]      dn_req_valid;
  logic [NPORT-1:0]      dn_req_ready;
  logic [XLEN-1:0]       dn_req_addr;
  logic                  dn_req_wen;
  logic [XLEN-1:0]       dn_req_wdata;
  logic [XLEN/8-1:0]     dn_req_wmask;
  // downstream responses
  logic [NPORT-1:0]      dn_resp_valid;
  logic [NPORT*XLEN-1:0] dn_resp_rdata;
  logic [NPORT-1:0]      dn_resp_error;

  modport slave (
    input  up_req_valid, up_req_addr, up_req_wen, up_req_wdata, up_req_wmask,
    input  dn_req_ready, dn_resp_valid, dn_resp_rdata, dn_resp_error,
    output up_req_ready, up_resp_valid, up_resp_rdata, up_resp_error, up_resp_errty,
    output dn_req_valid, dn_req_addr, dn_req_wen, dn_req_wdata, dn_req_wmask
  );

  modport master (
    output up_req_valid, up_req_addr, up_req_wen, up_req_wdata, up_req_wmask,
    output dn_req_ready, dn_resp_valid, dn_resp_rdata, dn_resp_error,
    input  up_req_ready, up_resp_valid, up_resp_rdata, up_resp_error, up_resp_errty,
    input  dn_req_valid, dn_req_addr, dn_req_wen, dn_req_wdata, dn_req_wmask
  );
endinterface

// File: rtl/mmio_router.sv
// MMIO request router: decodes each upstream request to one of NPORT
// targets (or a local decode error), forwards it with zero latency and
// returns responses in issue order through an in-order ID queue.
// Requests to a new port wait until the queue has drained, so each
// port's own in-order responses are also globally ordered.
module mmio_router #(
  parameter int                    XLEN         = 32,
  parameter int                    NPORT        = 4,
  parameter int                    DEPTH        = 4,
  parameter logic [NPORT*XLEN-1:0] PORT_BASE    = '0,
  parameter logic [NPORT*XLEN-1:0] PORT_END     = '0,
  parameter int                    DEFAULT_PORT = NPORT - 1
) (
  input  logic           clk,
  input  logic           reset_n,
  mmio_router_if.slave   bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam int             IDW      = $clog2(NPORT + 1);
  // ID value NPORT marks a request that matched no port (decode error)
  localparam logic [IDW-1:0] ERR_ID   = IDW'(NPORT);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  // queue control state
  logic [IDW-1:0]  r_q [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic [IDW-1:0]  r_last_id;
  logic            r_err_vld;

  // combinational decode / handshake
  logic [IDW-1:0]  w_sel;
  logic            w_full;
  logic            w_empty;
  logic            w_streak_ok;
  logic            w_issue_ok;
  logic            w_port_rdy;
  logic [NPORT-1:0] w_dn_vld;
  logic            w_push;
  logic            w_pop;

  // head-of-queue response selection
  logic [IDW-1:0]  w_head;
  logic            w_head_err;
  logic            w_hd_vld;
  logic            w_hd_err;
  logic [XLEN-1:0] w_hd_rdata;

  // next-state helpers
  logic [AW-1:0]   w_rd_n;
  logic [CW-1:0]   w_cnt_n;
  logic [IDW-1:0]  w_nhead;
  logic            w_err_vld_n;

  // Address decode: lowest-numbered matching port wins, else the default
  always_comb begin
    w_sel = IDW'(DEFAULT_PORT);
    for (int i = NPORT - 1; i >= 0; i--) begin
      if ((bus.up_req_addr >= PORT_BASE[i*XLEN +: XLEN]) &&
          (bus.up_req_addr <= PORT_END[i*XLEN +: XLEN])) begin
        w_sel = IDW'(i);
      end
    end
  end

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  // every queued entry equals the last pushed one, so one compare suffices
  assign w_streak_ok = w_empty || (r_last_id == w_sel);
  assign w_issue_ok  = !w_full && w_streak_ok;

  // Readiness of the selected target; decode errors never wait on a port
  always_comb begin
    w_port_rdy = (w_sel == ERR_ID);
    for (int i = 0; i < NPORT; i++) begin
      if (w_sel == IDW'(i)) w_port_rdy = bus.dn_req_ready[i];
    end
  end

  // One-hot request valid toward the selected port only
  always_comb begin
    w_dn_vld = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_dn_vld[i] = bus.up_req_valid && w_issue_ok && (w_sel == IDW'(i));
    end
  end

  assign bus.up_req_ready = w_issue_ok && w_port_rdy;
  assign bus.dn_req_valid = w_dn_vld;
  assign bus.dn_req_addr  = bus.up_req_addr;
  assign bus.dn_req_wen   = bus.up_req_wen;
  assign bus.dn_req_wdata = bus.up_req_wdata;
  assign bus.dn_req_wmask = bus.up_req_wmask;
  assign w_push           = bus.up_req_valid && bus.up_req_ready;

  assign w_head     = r_q[r_rd];
  assign w_head_err = (w_head == ERR_ID);

  // Pick the response lines of the port owning the head entry
  always_comb begin
    w_hd_vld   = 1'b0;
    w_hd_err   = 1'b0;
    w_hd_rdata = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_head == IDW'(i)) begin
        w_hd_vld   = bus.dn_resp_valid[i];
        w_hd_err   = bus.dn_resp_error[i];
        w_hd_rdata = bus.dn_resp_rdata[i*XLEN +: XLEN];
      end
    end
  end

  assign w_pop = !w_empty && (w_head_err ? r_err_vld : w_hd_vld);

  // Upstream response: local access fault for ERR, else pass-through
  always_comb begin
    bus.up_resp_valid = w_pop;
    bus.up_resp_rdata = '0;
    bus.up_resp_error = 1'b0;
    bus.up_resp_errty = 2'd0;
    if (w_pop) begin
      if (w_head_err) begin
        bus.up_resp_error = 1'b1;
        bus.up_resp_errty = 2'd1;
      end else begin
        bus.up_resp_rdata = w_hd_rdata;
        bus.up_resp_error = w_hd_err;
        bus.up_resp_errty = {1'b0, w_hd_err};
      end
    end
  end

  // Next pointers/count and the entry that will be head next cycle
  always_comb begin
    w_rd_n = w_pop ? (r_rd + AW'(1)) : r_rd;
    case ({w_push, w_pop})
      2'b10:   w_cnt_n = r_count + CW'(1);
      2'b01:   w_cnt_n = r_count - CW'(1);
      default: w_cnt_n = r_count;
    endcase
    // an entry pushed into an empty (or emptying) queue is not in r_q yet
    if (w_push && (w_empty || ((r_count == CW'(1)) && w_pop))) begin
      w_nhead = w_sel;
    end else begin
      w_nhead = r_q[w_rd_n];
    end
    w_err_vld_n = (w_cnt_n != '0) && (w_nhead == ERR_ID);
  end

  // Queue control registers and the registered decode-error strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_last_id <= '0;
      r_err_vld <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr      <= r_wr + AW'(1);
        r_last_id <= w_sel;
      end
      r_rd      <= w_rd_n;
      r_count   <= w_cnt_n;
      r_err_vld <= w_err_vld_n;
    end
  end

  // ID storage; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr] <= w_sel;
  end

endmodule

// File: tb/tb_mmio_router.sv
// Bench for mmio_router: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the router.
module tb_mmio_router;

  localparam int NPORT = 4;
  localparam int DEPTH = 4;
  localparam logic [NPORT*32-1:0] PB =
    {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NPORT*32-1:0] PE =
    {32'h1FFF_FFFF, 32'h2FFF_FFFF, 32'h1000_00FF, 32'h0FFF_FFFF};

  typedef struct {
    int          port;
    logic [31:0] addr;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mmio_router_if #(.XLEN(32), .NPORT(NPORT)) bus_e ();
  mmio_router_if #(.XLEN(32), .NPORT(NPORT)) bus_d ();

  mmio_router #(.XLEN(32), .NPORT(NPORT), .DEPTH(DEPTH), .PORT_BASE(PB),
                .PORT_END(PE), .DEFAULT_PORT(NPORT))
    u_dut_e (.clk(clk), .reset_n(reset_n), .bus(bus_e));

  mmio_router #(.XLEN(32), .NPORT(NPORT), .DEPTH(DEPTH), .PORT_BASE(PB),
                .PORT_END(PE), .DEFAULT_PORT(3))
    u_dut_d (.clk(clk), .reset_n(reset_n), .bus(bus_d));

  // stimulus for the main instance
  logic        u_valid, u_wen;
  logic [31:0] u_addr, u_wdata;
  logic [3:0]  u_wmask;
  logic [3:0]  d_rdy, d_rv, d_re;
  logic [31:0] d_rdata [NPORT];

  assign bus_e.up_req_valid  = u_valid;
  assign bus_e.up_req_addr   = u_addr;
  assign bus_e.up_req_wen    = u_wen;
  assign bus_e.up_req_wdata  = u_wdata;
  assign bus_e.up_req_wmask  = u_wmask;
  assign bus_e.dn_req_ready  = d_rdy;
  assign bus_e.dn_resp_valid = d_rv;
  assign bus_e.dn_resp_error = d_re;
  assign bus_e.dn_resp_rdata = {d_rdata[3], d_rdata[2], d_rdata[1], d_rdata[0]};

  // stimulus for the default-routing instance (decode checks only)
  logic        dd_valid;
  logic [31:0] dd_addr;
  assign bus_d.up_req_valid  = dd_valid;
  assign bus_d.up_req_addr   = dd_addr;
  assign bus_d.up_req_wen    = 1'b0;
  assign bus_d.up_req_wdata  = '0;
  assign bus_d.up_req_wmask  = '0;
  assign bus_d.dn_req_ready  = '1;
  assign bus_d.dn_resp_valid = '0;
  assign bus_d.dn_resp_error = '0;
  assign bus_d.dn_resp_rdata = '0;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state: requests in issue order, not yet answered
  ent_t        mq [$];
  logic [31:0] m_base [NPORT] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000};
  logic [31:0] m_end  [NPORT] = '{32'h0FFF_FFFF, 32'h1000_00FF, 32'h2FFF_FFFF, 32'h1FFF_FFFF};
  bit          m_push, m_pop;
  int          m_sel;
  logic [31:0] m_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_decode(input logic [31:0] a);
    for (int i = 0; i < NPORT; i++)
      if (a >= m_base[i] && a <= m_end[i]) return i;
    return NPORT;
  endfunction

  function automatic logic [31:0] rsp_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic rsp_err(input logic [31:0] a);
    return a[2] ^ a[9];
  endfunction

  // compare every DUT output with the model for the current cycle
  task automatic model_check();
    int          sel, hp;
    bit          full, streak, prdy, e_rdy, e_rv, e_er;
    logic [3:0]  e_dnv;
    logic [31:0] e_rd;
    logic [1:0]  e_ty;
    sel    = m_decode(u_addr);
    full   = (mq.size() >= DEPTH);
    streak = 1'b1;
    foreach (mq[i]) if (mq[i].port != sel) streak = 1'b0;
    prdy   = (sel == NPORT) ? 1'b1 : d_rdy[sel];
    e_rdy  = !full && streak && prdy;
    e_dnv  = '0;
    if (u_valid && !full && streak && sel < NPORT) e_dnv[sel] = 1'b1;
    e_rv = 1'b0; e_er = 1'b0; e_rd = '0; e_ty = 2'd0;
    if (mq.size() > 0) begin
      hp = mq[0].port;
      if (hp == NPORT) begin
        e_rv = 1'b1; e_er = 1'b1; e_ty = 2'd1;
      end else if (d_rv[hp]) begin
        e_rv = 1'b1; e_rd = d_rdata[hp]; e_er = d_re[hp]; e_ty = d_re[hp] ? 2'd1 : 2'd0;
      end
    end
    check_eq("up_req_ready", 64'(bus_e.up_req_ready), 64'(e_rdy));
    check_eq("dn_req_valid", 64'(bus_e.dn_req_valid), 64'(e_dnv));
    check_eq("dn_req_addr", 64'(bus_e.dn_req_addr), 64'(u_addr));
    check_eq("dn_req_payload", {27'd0, bus_e.dn_req_wen, bus_e.dn_req_wmask, bus_e.dn_req_wdata},
             {27'd0, u_wen, u_wmask, u_wdata});
    check_eq("up_resp_valid", 64'(bus_e.up_resp_valid), 64'(e_rv));
    if (e_rv) begin
      check_eq("up_resp_rdata", 64'(bus_e.up_resp_rdata), 64'(e_rd));
      check_eq("up_resp_err", 64'({bus_e.up_resp_error, bus_e.up_resp_errty}), 64'({e_er, e_ty}));
    end
    m_push = u_valid && e_rdy;
    m_pop  = e_rv;
    m_sel  = sel;
    m_addr = u_addr;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    model_check();
    @(posedge clk);
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back('{port: m_sel, addr: m_addr});
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic set_req(input logic [31:0] a);
    u_valid = 1'b1;
    u_addr  = a;
    u_wen   = 1'($urandom_range(0, 1));
    u_wdata = $urandom;
    u_wmask = 4'($urandom_range(0, 15));
  endtask

  // the target owning the head entry answers it this cycle
  task automatic resp_head();
    int p;
    if (mq.size() > 0 && mq[0].port < NPORT) begin
      p          = mq[0].port;
      d_rv[p]    = 1'b1;
      d_rdata[p] = rsp_data(mq[0].addr);
      d_re[p]    = rsp_err(mq[0].addr);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    u_valid = 1'b0;
    while (mq.size() > 0 && n < budget) begin
      d_rv = '0;
      resp_head();
      cyc();
      n++;
    end
    d_rv = '0;
    check_eq("drain_empty", 64'(mq.size()), 64'(0));
  endtask

  function automatic logic [31:0] rand_addr(input int cat);
    case (cat)
      0:       return $urandom % 32'h1000_0000;
      1:       return 32'h1000_0000 + ($urandom % 32'h100);
      2:       return 32'h2000_0000 + ($urandom % 32'h1000_0000);
      3:       return 32'h1000_0100 + ($urandom % 32'h0FFF_FF00);
      default: return 32'h3000_0000 + ($urandom % 32'hD000_0000);
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cat;
    reset_n = 1'b0;
    u_valid = 1'b0; u_addr = '0; u_wen = 1'b0; u_wdata = '0; u_wmask = '0;
    d_rdy = '1; d_rv = '0; d_re = '0;
    for (int i = 0; i < NPORT; i++) d_rdata[i] = '0;
    dd_valid = 1'b0; dd_addr = '0;

    // reset state
    @(negedge clk);
    check_eq("rst_resp_valid", 64'(bus_e.up_resp_valid), 64'(0));
    check_eq("rst_resp_payload", {29'd0, bus_e.up_resp_error, bus_e.up_resp_errty, bus_e.up_resp_rdata}, 64'(0));
    check_eq("rst_dn_valid", 64'(bus_e.dn_req_valid), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // default routing on the DEFAULT_PORT=3 instance
    dd_valid = 1'b1; dd_addr = 32'h8000_0000;
    #1 check_eq("dflt_route", 64'(bus_d.dn_req_valid), 64'(4'b1000));
    dd_addr = 32'h1000_0004;
    #1 check_eq("dflt_match", 64'(bus_d.dn_req_valid), 64'(4'b0010));
    dd_valid = 1'b0;

    // ready follows the selected port while empty
    set_req(32'h1000_0004);
    d_rdy = 4'b1101;
    settle();
    check_eq("empty_rdy_lo", 64'(bus_e.up_req_ready), 64'(0));
    tick();
    d_rdy = '1;

    // single read to port 1, answered three cycles later
    set_req(32'h1000_0004);
    settle();
    check_eq("rd_dn_valid", 64'(bus_e.dn_req_valid), 64'(4'b0010));
    tick();
    u_valid = 1'b0;
    cyc();
    cyc();
    d_rv[1] = 1'b1; d_rdata[1] = 32'hDEAD_BEEF; d_re[1] = 1'b0;
    settle();
    check_eq("rd_resp_valid", 64'(bus_e.up_resp_valid), 64'(1));
    check_eq("rd_resp_rdata", 64'(bus_e.up_resp_rdata), 64'(32'hDEAD_BEEF));
    check_eq("rd_resp_error", 64'(bus_e.up_resp_error), 64'(0));
    tick();
    d_rv = '0;

    // streak to port 0 until full, then one pop frees a slot next cycle
    for (int i = 0; i < 5; i++) begin
      set_req(32'h0000_0100 + 32'(4 * i));
      settle();
      if (i == 4) check_eq("full_rdy", 64'(bus_e.up_req_ready), 64'(0));
      tick();
    end
    resp_head();
    settle();
    check_eq("full_nobypass", 64'(bus_e.up_req_ready), 64'(0));
    check_eq("full_pop_resp", 64'(bus_e.up_resp_valid), 64'(1));
    tick();
    d_rv = '0;
    settle();
    check_eq("full_accept", 64'(bus_e.up_req_ready), 64'(1));
    tick();
    drain(20);

    // port switch waits for the drain
    set_req(32'h0000_0040);
    cyc();
    set_req(32'h2000_0010);
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("sw_stall", 64'(bus_e.dn_req_valid), 64'(0));
      tick();
    end
    resp_head();
    settle();
    check_eq("sw_pop_cycle", 64'(bus_e.up_req_ready), 64'(0));
    tick();
    d_rv = '0;
    settle();
    check_eq("sw_issue", 64'(bus_e.dn_req_valid), 64'(4'b0100));
    tick();
    drain(20);

    // decode error: local access fault one cycle after acceptance
    set_req(32'hFFFF_0000);
    settle();
    check_eq("derr_dn_valid", 64'(bus_e.dn_req_valid), 64'(0));
    check_eq("derr_ready", 64'(bus_e.up_req_ready), 64'(1));
    tick();
    u_valid = 1'b0;
    settle();
    check_eq("derr_resp_valid", 64'(bus_e.up_resp_valid), 64'(1));
    check_eq("derr_resp", {29'd0, bus_e.up_resp_error, bus_e.up_resp_errty, bus_e.up_resp_rdata},
             {29'd0, 1'b1, 2'd1, 32'd0});
    tick();
    settle();
    check_eq("derr_once", 64'(bus_e.up_resp_valid), 64'(0));
    tick();

    // reset with three requests outstanding
    for (int i = 0; i < 3; i++) begin
      set_req(32'h0000_0200 + 32'(4 * i));
      cyc();
    end
    u_valid = 1'b0;
    d_rv[0] = 1'b1; d_rdata[0] = 32'h1234_5678; d_re[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    mq.delete();
    #1 check_eq("rst_async_resp", 64'(bus_e.up_resp_valid), 64'(0));
    tick();
    reset_n = 1'b1;
    settle();
    check_eq("rst_late_resp", 64'(bus_e.up_resp_valid), 64'(0));
    tick();
    d_rv = '0;
    set_req(32'h2000_0040);
    settle();
    check_eq("rst_new_accept", 64'(bus_e.up_req_ready), 64'(1));
    tick();
    drain(20);

    // randomized traffic
    cat = 0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 99) >= 60) cat = $urandom_range(0, 4);
      u_valid = ($urandom_range(0, 99) < 70);
      u_addr  = rand_addr(cat);
      u_wen   = 1'($urandom_range(0, 1));
      u_wdata = $urandom;
      u_wmask = 4'($urandom_range(0, 15));
      for (int i = 0; i < NPORT; i++) begin
        d_rdy[i]   = ($urandom_range(0, 99) < 85);
        d_rdata[i] = $urandom;
      end
      d_re = 4'($urandom_range(0, 15));
      d_rv = '0;
      if ($urandom_range(0, 99) < 50) resp_head();
      cyc();
    end
    drain(64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
